// File: rtl/hdmi_video_timing.sv
// Raster timing generator for the HDMI pixel clock: waits for a synchronized,
// settled PLL lock, then emits registered sync, data-enable, coordinates and strobes.
module hdmi_video_timing #(
  parameter int H_ACTIVE      = 1280,
  parameter int H_FP          = 110,
  parameter int H_SYNC        = 40,
  parameter int H_BP          = 220,
  parameter int V_ACTIVE      = 720,
  parameter int V_FP          = 5,
  parameter int V_SYNC        = 5,
  parameter int V_BP          = 20,
  parameter bit H_POL         = 1'b1,
  parameter bit V_POL         = 1'b1,
  parameter int SETTLE_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pll_lock,
  output logic        running,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [11:0] x,
  output logic [10:0] y,
  output logic        line_start,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int SW      = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [11:0]   H_LAST  = 12'(H_TOTAL - 1);
  localparam logic [10:0]   V_LAST  = 11'(V_TOTAL - 1);
  localparam logic [11:0]   H_ACT   = 12'(H_ACTIVE);
  localparam logic [10:0]   V_ACT   = 11'(V_ACTIVE);
  localparam logic [11:0]   HS_BEG  = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0]   HS_END  = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0]   VS_BEG  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0]   VS_END  = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [SW-1:0] ST_LAST = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {WAIT_LOCK, SETTLE, RUN} state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [11:0]   h_q, h_d;
  logic [10:0]   v_q, v_d;
  logic          lock_meta_q, lock_sync_q;

  logic          running_d, hsync_d, vsync_d, de_d, line_start_d, frame_start_d;
  logic [11:0]   x_d;
  logic [10:0]   y_d;
  logic          active;

  // State, counters, synchronizer and output registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
      state_q     <= WAIT_LOCK;
      settle_q    <= '0;
      h_q         <= '0;
      v_q         <= '0;
      running     <= 1'b0;
      hsync       <= ~H_POL;
      vsync       <= ~V_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      lock_meta_q <= pll_lock;
      lock_sync_q <= lock_meta_q;
      state_q     <= state_d;
      settle_q    <= settle_d;
      h_q         <= h_d;
      v_q         <= v_d;
      running     <= running_d;
      hsync       <= hsync_d;
      vsync       <= vsync_d;
      de          <= de_d;
      x           <= x_d;
      y           <= y_d;
      line_start  <= line_start_d;
      frame_start <= frame_start_d;
    end
  end

  // The first clock with synced lock high counts as settle clock 0.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves one unassigned (no latch).
    state_d  = state_q;
    settle_d = settle_q;
    h_d      = h_q;
    v_d      = v_q;
    unique case (state_q)
      WAIT_LOCK: begin
        settle_d = '0;
        h_d      = '0;
        v_d      = '0;
        if (lock_sync_q) begin
          if (SETTLE_CYCLES == 1) begin
            state_d = RUN;
          end else begin
            state_d  = SETTLE;
            settle_d = SW'(1);
          end
        end
      end
      SETTLE: begin
        if (!lock_sync_q) begin
          state_d  = WAIT_LOCK;
          settle_d = '0;
        end else if (settle_q == ST_LAST) begin
          state_d  = RUN;
          settle_d = '0;
          h_d      = '0;
          v_d      = '0;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      RUN: begin
        if (!lock_sync_q) begin
          state_d = WAIT_LOCK;
          h_d     = '0;
          v_d     = '0;
        end else if (h_q == H_LAST) begin
          h_d = '0;
          v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end else begin
          h_d = h_q + 1'b1;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  // Gating on the synced lock idles the outputs on the edge right after lock is lost.
  always_comb begin
    active        = (state_q == RUN) && lock_sync_q;
    running_d     = active;
    de_d          = active && (h_q < H_ACT) && (v_q < V_ACT);
    hsync_d       = (active && (h_q >= HS_BEG) && (h_q < HS_END)) ? H_POL : ~H_POL;
    vsync_d       = (active && (v_q >= VS_BEG) && (v_q < VS_END)) ? V_POL : ~V_POL;
    line_start_d  = active && (h_q == '0);
    frame_start_d = active && (h_q == '0) && (v_q == '0);
    x_d           = de_d ? h_q : '0;
    y_d           = de_d ? v_q : '0;
  end

endmodule

// File: tb/tb_hdmi_video_timing.sv
// Self-checking bench for hdmi_video_timing on a 16x8 raster; the reference model
// derives every output from how long the synchronized lock has been continuously high.
module tb_hdmi_video_timing;

  localparam int HA = 8, HF = 2, HS = 3, HB = 3;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int ST = 4;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic        clk = 1'b0;
  logic        rst;
  logic        pll_lock;
  logic        running, hsync, vsync, de, line_start, frame_start;
  logic [11:0] x;
  logic [10:0] y;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: synchronizer image plus run length of synced-high clocks.
  bit m_meta, m_sync;
  int m_rl;

  logic        e_running, e_de, e_hs, e_vs, e_ls, e_fs;
  logic [11:0] e_x;
  logic [10:0] e_y;

  hdmi_video_timing #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_POL(1'b1), .V_POL(1'b1), .SETTLE_CYCLES(ST)
  ) dut (
    .clk(clk), .rst(rst), .pll_lock(pll_lock),
    .running(running), .hsync(hsync), .vsync(vsync), .de(de),
    .x(x), .y(y), .line_start(line_start), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: the DUT runs RUN for t = run_length - (ST+1) clocks after the edge that
  // starts it, so outputs follow from that elapsed time with modulo arithmetic.
  task automatic tick();
    bit act;
    int t, hh, vv;
    @(posedge clk);
    act = 1'b0;
    t   = 0;
    if (rst) begin
      m_meta = 1'b0;
      m_sync = 1'b0;
      m_rl   = 0;
    end else begin
      act    = (m_rl >= ST + 1);
      t      = m_rl - (ST + 1);
      m_sync = m_meta;
      m_meta = pll_lock;
      m_rl   = m_sync ? m_rl + 1 : 0;
    end
    hh        = act ? t % HT : 0;
    vv        = act ? (t / HT) % VT : 0;
    e_running = act;
    e_de      = act && hh < HA && vv < VA;
    e_hs      = act && hh >= HA + HF && hh < HA + HF + HS;
    e_vs      = act && vv >= VA + VF && vv < VA + VF + VS;
    e_ls      = act && hh == 0;
    e_fs      = act && (t % (HT * VT)) == 0;
    e_x       = e_de ? 12'(hh) : 12'd0;
    e_y       = e_de ? 11'(vv) : 11'd0;
    #1;
    check("running",     16'(running),     16'(e_running));
    check("de",          16'(de),          16'(e_de));
    check("hsync",       16'(hsync),       16'(e_hs));
    check("vsync",       16'(vsync),       16'(e_vs));
    check("line_start",  16'(line_start),  16'(e_ls));
    check("frame_start", 16'(frame_start), 16'(e_fs));
    check("x",           16'(x),           16'(e_x));
    check("y",           16'(y),           16'(e_y));
  endtask

  task automatic wait_xy(input int wx, input int wy);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 2 * HT * VT && !found; i++) begin
      tick();
      if (de === 1'b1 && x == 12'(wx) && y == 11'(wy)) found = 1'b1;
    end
    check("wait_xy", 16'(found), 16'(1));
  endtask

  task automatic expect_startup(input string tag);
    for (int i = 1; i <= 7; i++) begin
      tick();
      check(tag, 16'(frame_start), 16'(i == 7));
      check(tag, 16'(running), 16'(i == 7));
    end
    check({tag, "_de"}, 16'(de), 16'(1));
    check({tag, "_x"}, 16'(x), 16'(0));
    check({tag, "_y"}, 16'(y), 16'(0));
  endtask

  initial begin
    int c_de, c_hs, c_vs, c_ls, c_fs;
    int hi, lo;

    // Reset with lock already high: outputs sit at reset values.
    rst      = 1'b1;
    pll_lock = 1'b1;
    repeat (3) tick();
    check("rst_hsync", 16'(hsync), 16'(0));
    check("rst_running", 16'(running), 16'(0));

    // Startup: first frame_start seven clocks after release.
    rst = 1'b0;
    expect_startup("startup");

    // Over any window of one frame period the strobe and enable counts are fixed.
    c_de = 0; c_hs = 0; c_vs = 0; c_ls = 0; c_fs = 0;
    for (int i = 0; i < HT * VT; i++) begin
      tick();
      if (de)          c_de++;
      if (hsync)       c_hs++;
      if (vsync)       c_vs++;
      if (line_start)  c_ls++;
      if (frame_start) c_fs++;
    end
    check("de_per_frame",    16'(c_de), 16'(HA * VA));
    check("hsync_per_frame", 16'(c_hs), 16'(HS * VT));
    check("vsync_per_frame", 16'(c_vs), 16'(VS * HT));
    check("ls_per_frame",    16'(c_ls), 16'(VT));
    check("fs_per_frame",    16'(c_fs), 16'(1));

    // Lock loss mid-line at x=5, y=2.
    wait_xy(5, 2);
    pll_lock = 1'b0;
    tick();
    tick();
    check("loss_still_running", 16'(running), 16'(1));
    tick();
    check("loss_running", 16'(running), 16'(0));
    check("loss_de",      16'(de),      16'(0));
    check("loss_hsync",   16'(hsync),   16'(0));
    check("loss_vsync",   16'(vsync),   16'(0));
    repeat (3) tick();
    pll_lock = 1'b1;
    expect_startup("relock");

    // Glitch during SETTLE restarts the settle period.
    pll_lock = 1'b0;
    repeat (4) tick();
    pll_lock = 1'b1;
    repeat (3) tick();
    pll_lock = 1'b0;
    repeat (3) tick();
    pll_lock = 1'b1;
    expect_startup("glitch");

    // Synchronous reset mid-frame while running.
    wait_xy(3, 1);
    rst = 1'b1;
    tick();
    check("srst_running", 16'(running),     16'(0));
    check("srst_de",      16'(de),          16'(0));
    check("srst_x",       16'(x),           16'(0));
    check("srst_fs",      16'(frame_start), 16'(0));
    repeat (2) tick();
    rst = 1'b0;
    expect_startup("after_rst");

    // Random lock drops, glitches and resets against the model.
    for (int s = 0; s < 30; s++) begin
      hi = $urandom_range(1, 300);
      lo = $urandom_range(1, 4);
      pll_lock = 1'b1;
      repeat (hi) tick();
      pll_lock = 1'b0;
      repeat (lo) tick();
      if ($urandom_range(0, 7) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
    end
    pll_lock = 1'b1;
    repeat (2 * HT * VT) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hdmi_video_timing.md
# hdmi_video_timing

Raster timing generator driven by the pixel-clock output of the HDMI PLL. It qualifies startup on the PLL lock, then produces registered hsync/vsync/data-enable, pixel coordinates and frame/line strobes for the pixel source and TMDS encoder downstream. Default parameters give 1280x720p60 (CEA-861, 74.25 MHz pixel clock).

## Interface
Parameters:
- H_ACTIVE, 1280, active pixels per line
- H_FP, 110, horizontal front porch (clocks)
- H_SYNC, 40, hsync width (clocks)
- H_BP, 220, horizontal back porch (clocks)
- V_ACTIVE, 720, active lines per frame
- V_FP, 5, vertical front porch (lines)
- V_SYNC, 5, vsync width (lines)
- V_BP, 20, vertical back porch (lines)
- H_POL, 1, hsync asserted level (1 = positive)
- V_POL, 1, vsync asserted level
- SETTLE_CYCLES, 1024, clocks to wait after synchronized lock before running; minimum 1

Ports:
- clk  in  1  pixel clock (PLL divided output)
- rst  in  1  synchronous, active-high reset
- pll_lock  in  1  PLL lock; asynchronous to clk
- running  out  1  high while in RUN
- hsync  out  1  horizontal sync, polarity per H_POL
- vsync  out  1  vertical sync, polarity per V_POL
- de  out  1  active-video enable
- x  out  12  pixel column; valid when de=1
- y  out  11  line number; valid when de=1
- line_start  out  1  one-clock pulse at h=0 of every line (active and blanking)
- frame_start  out  1  one-clock pulse at h=0, v=0

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Internal counters h in [0, H_TOTAL-1], v in [0, V_TOTAL-1].
- pll_lock passes through a two-flop synchronizer (reset to 0) before any use.
- States: WAIT_LOCK, SETTLE, RUN. Reset -> WAIT_LOCK.
  - WAIT_LOCK: counters held at 0; go to SETTLE when synced lock = 1.
  - SETTLE: settle counter counts 0..SETTLE_CYCLES-1; after the final count go to RUN with h=v=0. Synced lock = 0 -> WAIT_LOCK, settle counter cleared.
  - RUN: h increments every clock; at H_TOTAL-1, h wraps to 0 and v increments; at v=V_TOTAL-1 and h=H_TOTAL-1, both wrap to 0. Synced lock = 0 -> WAIT_LOCK, counters cleared, no partial-frame completion.
- Decode (from counters, RUN only): de = h<H_ACTIVE && v<V_ACTIVE; hsync asserted for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vsync asserted for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC) and changes at h=0; line_start = (h==0); frame_start = (h==0 && v==0).
- x = h, y = v when de; x and y hold 0 when de=0.
- Outside RUN every output is at its idle value.

## Timing
- All outputs registered; each output reflects the counter state of the previous cycle (latency 1). running is registered from the state (high the cycle after the state becomes RUN), so it rises in the same cycle as the first frame_start.
- Reset values: running=0, de=0, x=0, y=0, line_start=0, frame_start=0, hsync=~H_POL, vsync=~V_POL.
- Lock to first output: synced lock is high 2 clocks after pll_lock rises; SETTLE lasts SETTLE_CYCLES clocks; frame_start (with de=1, x=0, y=0) appears 1 clock after entering RUN.
- Lock loss: synced lock falls 2 clocks after pll_lock; the following edge forces all outputs to idle.
- rst has priority over all other inputs; asserting it mid-frame gives reset values on the next edge.
- A pll_lock glitch shorter than one clock may be missed; any synced low restarts the full SETTLE period.

## Test plan
Use a small configuration for simulation: H 8/2/3/3 (H_TOTAL=16), V 4/1/2/1 (V_TOTAL=8), SETTLE_CYCLES=4, H_POL=V_POL=1.
- Startup: rst for 3 clocks, pll_lock=1 from cycle 0 -> running and first frame_start in the same cycle, 7 clocks after rst deasserts (2 sync + 4 settle + 1 output register), with de=1, x=0, y=0; before that, all outputs at reset values.
- Line timing: over one line -> de high for 8 clocks with x=0..7; hsync high for clocks 10-12 (3 clocks); line_start exactly every 16 clocks.
- Frame timing: vsync high for lines 5-6 (32 clocks), with edges aligned to line_start; de never high on lines 4-7; frame_start exactly every 128 clocks; y=0..3 on active lines.
- Lock loss mid-line: drop pll_lock at x=5, y=2 -> 2 clocks later plus 1 edge, running=0, de=0, hsync=0, vsync=0; re-raise lock -> full 4-clock settle, then frame_start with x=0, y=0.
- Lock glitch during SETTLE: drop pll_lock for 3 clocks mid-settle -> settle restarts; first frame_start comes 7 clocks after lock returns.
- Sync reset mid-frame while running: rst=1 at y=1, x=3 -> next edge gives reset values on all outputs; after release with lock high, normal startup timing as in the first scenario.
